// File: rtl/reg_file_8x8.sv
// Operand register file for the lab5 datapath: 2^ADDR_WIDTH registers, two registered read ports, one write port.
// Define REG_FILE_WRITE_FORWARD_EN for write-first read ports; default build is read-first.
module reg_file_8x8 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITEENABLE,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   output logic [DATA_WIDTH-1:0] REGOUT1,
   output logic [DATA_WIDTH-1:0] REGOUT2
);

   localparam int NumRegs = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NumRegs];
   logic [DATA_WIDTH-1:0] regs_d [NumRegs];
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;

   always_comb begin
      regs_d = regs_q;
      if (WRITEENABLE) begin
         regs_d[INADDRESS] = IN;
      end
`ifdef REG_FILE_WRITE_FORWARD_EN
      // Reading the post-write array gives write-first behaviour on a colliding address.
      rdata1_d = regs_d[OUT1ADDRESS];
      rdata2_d = regs_d[OUT2ADDRESS];
`else
      rdata1_d = regs_q[OUT1ADDRESS];
      rdata2_d = regs_q[OUT2ADDRESS];
`endif
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
         end
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

   assign REGOUT1 = rdata1_q;
   assign REGOUT2 = rdata2_q;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Scoreboard bench for reg_file_8x8: a driver pushes expected read data from an array model,
// a monitor pops one entry per rising edge and compares it with REGOUT1/REGOUT2.
module tb_reg_file_8x8;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] IN = '0;
   logic [2:0] INADDRESS = '0;
   logic       WRITEENABLE = 1'b0;
   logic [2:0] OUT1ADDRESS = '0;
   logic [2:0] OUT2ADDRESS = '0;
   logic [7:0] REGOUT1;
   logic [7:0] REGOUT2;

`ifdef REG_FILE_WRITE_FORWARD_EN
   localparam bit WriteFirst = 1'b1;
`else
   localparam bit WriteFirst = 1'b0;
`endif

   typedef struct {
      bit         chk;
      logic [7:0] e1;
      logic [7:0] e2;
      string      tag;
   } exp_t;

   exp_t       sbQ[$];
   logic [7:0] model [8];
   int         total = 0;
   int         bad = 0;
   logic [7:0] sumVal;

   reg_file_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .IN(IN),
      .INADDRESS(INADDRESS),
      .WRITEENABLE(WRITEENABLE),
      .OUT1ADDRESS(OUT1ADDRESS),
      .OUT2ADDRESS(OUT2ADDRESS),
      .REGOUT1(REGOUT1),
      .REGOUT2(REGOUT2)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Expected read data follows the register semantics: reset clears, a colliding write is visible only in write-first mode.
   function automatic logic [7:0] expectRead(input bit rst, input bit we, input logic [2:0] wa,
                                             input logic [7:0] wd, input logic [2:0] ra);
      if (rst) return 8'h00;
      if (WriteFirst && we && (wa == ra)) return wd;
      return model[ra];
   endfunction

   task automatic applyStimulus(input bit rst, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                                input logic [2:0] a1, input logic [2:0] a2, input bit chk, input string tag);
      exp_t e;
      @(negedge CLK);
      RESET = rst;
      WRITEENABLE = we;
      INADDRESS = wa;
      IN = wd;
      OUT1ADDRESS = a1;
      OUT2ADDRESS = a2;
      e.chk = chk;
      e.e1 = expectRead(rst, we, wa, wd, a1);
      e.e2 = expectRead(rst, we, wa, wd, a2);
      e.tag = tag;
      sbQ.push_back(e);
      if (rst) begin
         for (int i = 0; i < 8; i++) model[i] = 8'h00;
      end else if (we) begin
         model[wa] = wd;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.chk) begin
               checkOutput({e.tag, "_out1"}, REGOUT1, e.e1);
               checkOutput({e.tag, "_out2"}, REGOUT2, e.e2);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      // Contents are undefined before the first reset, so this edge is not checked.
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, "prereset");
      applyStimulus(1, 0, 0, 8'h00, 0, 0, 1, "reset");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0, 8'h00, 3'(i), 3'(7 - i), 1, "reset_read");
      end

      applyStimulus(0, 1, 3, 8'h5A, 3, 7, 1, "write_r3");
      applyStimulus(0, 1, 7, 8'hA5, 3, 7, 1, "write_r7");
      applyStimulus(0, 0, 0, 8'h00, 3, 7, 1, "read_r3_r7");

      applyStimulus(0, 0, 3, 8'hFF, 3, 3, 1, "we_off");
      applyStimulus(0, 0, 0, 8'h00, 3, 0, 1, "we_off_after");

      applyStimulus(0, 1, 2, 8'h11, 0, 1, 1, "write_r2");
      applyStimulus(0, 1, 2, 8'h22, 2, 2, 1, "collision");
      applyStimulus(0, 0, 0, 8'h00, 2, 2, 1, "collision_next");

      applyStimulus(0, 1, 4, 8'h3C, 4, 4, 1, "write_r4");
      applyStimulus(1, 1, 4, 8'h7E, 4, 4, 1, "reset_beats_write");
      applyStimulus(0, 0, 0, 8'h00, 4, 3, 1, "after_reset");

      applyStimulus(0, 1, 1, 8'h7F, 0, 0, 1, "adder_r1");
      applyStimulus(0, 1, 2, 8'h01, 0, 0, 1, "adder_r2");
      applyStimulus(0, 0, 0, 8'h00, 1, 2, 1, "adder_read");
      @(posedge CLK);
      #1;
      sumVal = REGOUT1 + REGOUT2;
      checkOutput("adder_sum", sumVal, 8'h80);
      applyStimulus(0, 1, 5, sumVal, 0, 0, 1, "adder_write");
      applyStimulus(0, 0, 0, 8'h00, 5, 5, 1, "adder_r5");

      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 39) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                       8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1, "random");
      end

      repeat (3) @(negedge CLK);
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain actual=%0d required=0", sbQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
